// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width and the ID/EX control-bundle layout.
package cpu_pkg;
   localparam int XLEN           = 32;
   localparam int CTRL_W         = 7;
   localparam int CTRL_REGWRITE  = 6;
   localparam int CTRL_MEMTOREG  = 5;
   localparam int CTRL_MEMREAD   = 4;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_ALUOP_HI  = 2;
   localparam int CTRL_ALUOP_LO  = 1;
   localparam int CTRL_ALUSRC    = 0;

   typedef enum logic {
      NORMAL = 1'b0,
      BUBBLE = 1'b1
   } stageMode_e;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic       exMemRead,
   input  logic [4:0] exRd,
   input  logic [4:0] idRs1,
   input  logic [4:0] idRs2,
   input  logic       usesRs2,
   input  logic       flush,
   output logic       haz,
   output logic       stall,
   output logic       pcWrite,
   output logic       ifIdWrite
);
   logic rs1Match, rs2Match;

   assign rs1Match  = (exRd == idRs1);
   assign rs2Match  = usesRs2 & (exRd == idRs2);
   assign haz       = exMemRead & (exRd != 5'd0) & (rs1Match | rs2Match);
   // A squashed ID instruction must not freeze fetch; the branch redirect wins.
   assign stall     = haz & ~flush;
   assign pcWrite   = ~stall;
   assign ifIdWrite = ~stall;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int CTRL_W = cpu_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [4:0]        IF_ID_RS1_i,
   input  logic [4:0]        IF_ID_RS2_i,
   input  logic [4:0]        IF_ID_Rd_i,
   input  logic              UsesRS2_i,
   input  logic [CTRL_W-1:0] Ctrl_i,
   input  logic [XLEN-1:0]   RS1Data_i,
   input  logic [XLEN-1:0]   RS2Data_i,
   input  logic [XLEN-1:0]   Imm_i,
   input  logic [9:0]        Funct_i,
   input  logic              Flush_i,
   output logic [CTRL_W-1:0] Ctrl_o,
   output logic [XLEN-1:0]   RS1Data_o,
   output logic [XLEN-1:0]   RS2Data_o,
   output logic [XLEN-1:0]   Imm_o,
   output logic [9:0]        Funct_o,
   output logic [4:0]        ID_EX_RS1_o,
   output logic [4:0]        ID_EX_RS2_o,
   output logic [4:0]        ID_EX_Rd_o,
   output logic              PCWrite_o,
   output logic              IF_ID_Write_o,
   output logic              Stall_o,
   output logic [CNT_W-1:0]  BubbleCnt_o
);
   logic       haz;
   stageMode_e mode;

   hazard_detect uHazard (
      .exMemRead (Ctrl_o[CTRL_MEMREAD]),
      .exRd      (ID_EX_Rd_o),
      .idRs1     (IF_ID_RS1_i),
      .idRs2     (IF_ID_RS2_i),
      .usesRs2   (UsesRS2_i),
      .flush     (Flush_i),
      .haz       (haz),
      .stall     (Stall_o),
      .pcWrite   (PCWrite_o),
      .ifIdWrite (IF_ID_Write_o)
   );

   assign mode = (haz | Flush_i) ? BUBBLE : NORMAL;

   // Only the control bundle is zeroed on a bubble; with Ctrl=0 the rest is inert.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         Ctrl_o      <= '0;
         RS1Data_o   <= '0;
         RS2Data_o   <= '0;
         Imm_o       <= '0;
         Funct_o     <= '0;
         ID_EX_RS1_o <= '0;
         ID_EX_RS2_o <= '0;
         ID_EX_Rd_o  <= '0;
      end else begin
         Ctrl_o      <= (mode == BUBBLE) ? '0 : Ctrl_i;
         RS1Data_o   <= RS1Data_i;
         RS2Data_o   <= RS2Data_i;
         Imm_o       <= Imm_i;
         Funct_o     <= Funct_i;
         ID_EX_RS1_o <= IF_ID_RS1_i;
         ID_EX_RS2_o <= IF_ID_RS2_i;
         ID_EX_Rd_o  <= IF_ID_Rd_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         BubbleCnt_o <= '0;
      else if (mode == BUBBLE && BubbleCnt_o != {CNT_W{1'b1}})
         BubbleCnt_o <= BubbleCnt_o + 1'b1;
   end
endmodule
